// File: rtl/alu_uart_requester.sv
// Host-side requester for the UART ALU protocol: sends A, B and the opcode as three
// TX bytes, then waits (with a timeout) for the single result byte on the RX side.
module alu_uart_requester #(
    parameter int N       = 7,
    parameter int TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [N:0] a,
    input  logic [N:0] b,
    input  logic [5:0] op,
    output logic       busy,
    output logic       done,
    output logic       err_timeout,
    output logic [N:0] result,
    output logic [N:0] w_data,
    output logic       wr_uart,
    input  logic       tx_full,
    input  logic [N:0] r_data,
    output logic       rd_uart,
    input  logic       rx_empty
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        SEND_OP,
        WAIT_RES,
        DONE
    } state_t;

    state_t        state_q;
    logic [N:0]    a_q;
    logic [N:0]    b_q;
    logic [5:0]    op_q;
    logic [CW-1:0] cnt_q;
    logic [N:0]    result_q;
    logic [N:0]    w_data_q;
    logic          wr_uart_q;
    logic          rd_uart_q;
    logic          done_q;
    logic          err_timeout_q;
    logic [N:0]    op_byte_d;

    // Opcode zero-extended to a full byte; written this way so N=5 needs no zero-width fill.
    always_comb begin
        op_byte_d      = '0;
        op_byte_d[5:0] = op_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            cnt_q         <= '0;
            result_q      <= '0;
            w_data_q      <= '0;
            wr_uart_q     <= 1'b0;
            rd_uart_q     <= 1'b0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            wr_uart_q     <= 1'b0;
            rd_uart_q     <= 1'b0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // rx_empty lags a pop by one cycle, so never decide on it right after popping.
                    if (!rx_empty && !rd_uart_q) begin
                        rd_uart_q <= 1'b1;
                    end else if (start && rx_empty && !rd_uart_q) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        state_q <= SEND_A;
                    end
                end
                SEND_A: begin
                    if (!tx_full) begin
                        wr_uart_q <= 1'b1;
                        w_data_q  <= a_q;
                        state_q   <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (!tx_full) begin
                        wr_uart_q <= 1'b1;
                        w_data_q  <= b_q;
                        state_q   <= SEND_OP;
                    end
                end
                SEND_OP: begin
                    if (!tx_full) begin
                        wr_uart_q <= 1'b1;
                        w_data_q  <= op_byte_d;
                        cnt_q     <= '0;
                        state_q   <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (!rx_empty) begin
                        rd_uart_q <= 1'b1;
                        result_q  <= r_data;
                        done_q    <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_timeout_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err_timeout = err_timeout_q;
    assign result      = result_q;
    assign w_data      = w_data_q;
    assign wr_uart     = wr_uart_q;
    assign rd_uart     = rd_uart_q;

endmodule

// File: tb/tb_alu_uart_requester.sv
// Randomised bench for alu_uart_requester: the TX/RX FIFOs and the remote ALU are
// modelled with queues, and a negedge monitor scores every strobe against expectations.
module tb_alu_uart_requester;

    localparam int N       = 7;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [5:0] op = '0;
    logic       busy;
    logic       done;
    logic       err_timeout;
    logic [7:0] result;
    logic [7:0] w_data;
    logic       wr_uart;
    logic       tx_full = 1'b0;
    logic [7:0] r_data = '0;
    logic       rd_uart;
    logic       rx_empty = 1'b1;

    alu_uart_requester #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .op          (op),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .result      (result),
        .w_data      (w_data),
        .wr_uart     (wr_uart),
        .tx_full     (tx_full),
        .r_data      (r_data),
        .rd_uart     (rd_uart),
        .rx_empty    (rx_empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard state
    logic [7:0] exp_tx[$];
    logic [7:0] exp_res[$];
    int         exp_to = 0;
    logic [7:0] rx_q[$];
    logic [7:0] inj_q[$];
    logic [7:0] prev_res = '0;

    int   cyc = 0;
    logic full_at_edge = 1'b0;
    int   wr_cnt = 0, rd_cnt = 0, done_cnt = 0, to_cnt = 0;
    int   last_wr_cyc = 0, done_cyc = 0, to_cyc = 0;
    logic rd_prev = 1'b0, done_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Remote ALU: MIPS-style funct codes; anything else answers zero.
    function automatic logic [7:0] alu_model(input logic [7:0] x, input logic [7:0] y,
                                             input logic [5:0] f);
        case (f)
            6'h20:   return x + y;
            6'h22:   return x - y;
            6'h24:   return x & y;
            6'h25:   return x | y;
            6'h26:   return x ^ y;
            6'h27:   return ~(x | y);
            default: return 8'h00;
        endcase
    endfunction

    // RX FIFO (first-word-fall-through, flags update one edge after a pop) and edge bookkeeping.
    always @(posedge clk) begin
        cyc          <= cyc + 1;
        full_at_edge <= tx_full;
        if (rd_uart) begin
            if (rx_q.size() > 0) void'(rx_q.pop_front());
            else chk("rd_on_empty_fifo", 1, 0);
        end
        while (inj_q.size() > 0) rx_q.push_back(inj_q.pop_front());
        rx_empty <= (rx_q.size() == 0);
        r_data   <= (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end

    // Monitor: pops expectations whenever the DUT strobes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_uart) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                chk("wr_while_full", {31'b0, full_at_edge}, 0);
                if (exp_tx.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("w_data", {24'b0, w_data}, {24'b0, exp_tx.pop_front()});
                $display("tx write %02h at cycle %0d", w_data, cyc);
            end
            if (rd_uart) begin
                rd_cnt++;
                chk("rd_back_to_back", {31'b0, rd_prev}, 0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_single_cycle", {31'b0, done_prev}, 0);
                if (exp_res.size() == 0) chk("done_unexpected", 1, 0);
                else chk("result", {24'b0, result}, {24'b0, exp_res.pop_front()});
                $display("done result %02h at cycle %0d", result, cyc);
            end
            if (err_timeout) begin
                to_cnt++;
                to_cyc = cyc;
                chk("timeout_expected", (exp_to > 0) ? 1 : 0, 1);
                if (exp_to > 0) exp_to--;
                $display("timeout at cycle %0d", cyc);
            end
        end
        rd_prev   = rd_uart & rst_n;
        done_prev = done & rst_n;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_wr(input int n, output bit ok);
        int t = 0;
        while (wr_cnt < n && t < 100) begin
            tick();
            t++;
        end
        ok = (wr_cnt >= n);
        if (!ok) chk("wr_wait_expired", wr_cnt, n);
    endtask

    // mode 0: reply dly cycles after the opcode write; 1: reply queued right after the A
    // write (minimum latency); 2: no reply (timeout).
    task automatic frame(input logic [7:0] av, input logic [7:0] bv, input logic [5:0] opv,
                         input int stall, input int mode, input int dly);
        logic [7:0] rep;
        int w0, d0, r0, t0, acc, awc, opc, t;
        bit ok;
        rep = alu_model(av, bv, opv);
        exp_tx.push_back(av);
        exp_tx.push_back(bv);
        exp_tx.push_back({2'b00, opv});
        if (mode != 2) exp_res.push_back(rep);
        else exp_to++;
        $display("frame a=%02h b=%02h op=%02h stall=%0d mode=%0d dly=%0d", av, bv, opv, stall, mode, dly);
        w0 = wr_cnt; d0 = done_cnt; t0 = to_cnt;
        start = 1'b1; a = av; b = bv; op = opv;
        t = 0;
        while (!busy && t < 40) begin
            tick();
            t++;
        end
        chk("start_accepted", {31'b0, busy}, 1);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 6'($urandom);
        if (!busy) return;
        acc = cyc;
        r0  = rd_cnt;
        wait_wr(w0 + 1, ok);
        if (!ok) return;
        awc = last_wr_cyc;
        chk("a_write_latency", awc - acc, 1);
        if (mode == 1) inj_q.push_back(rep);
        if (stall > 0) begin
            tx_full = 1'b1;
            repeat (stall) tick();
            tx_full = 1'b0;
        end
        wait_wr(w0 + 3, ok);
        if (!ok) return;
        opc = last_wr_cyc;
        chk("frame_write_span", opc - awc, 2 + stall);
        if (mode == 2) begin
            t = 0;
            while (to_cnt == t0 && t < TIMEOUT + 20) begin
                tick();
                t++;
            end
            chk("timeout_seen", to_cnt - t0, 1);
            chk("timeout_latency", to_cyc - opc, TIMEOUT);
            chk("busy_after_timeout", {31'b0, busy}, 0);
            tick();
            chk("no_done_on_timeout", done_cnt - d0, 0);
            chk("result_kept", {24'b0, result}, {24'b0, prev_res});
        end else begin
            if (mode == 0) begin
                repeat (dly) tick();
                inj_q.push_back(rep);
            end
            t = 0;
            while (done_cnt == d0 && t < 60) begin
                tick();
                t++;
            end
            chk("done_seen", done_cnt - d0, 1);
            if (mode == 1) chk("min_latency", done_cyc - acc, 4 + stall);
            else chk("reply_latency", done_cyc - opc, dly + 2);
            chk("busy_in_guard", {31'b0, busy}, 1);
            tick();
            chk("busy_low_after_guard", {31'b0, busy}, 0);
            chk("single_pop", rd_cnt - r0, 1);
            prev_res = rep;
        end
    endtask

    initial begin
        int r_before, d_before, w0;
        bit ok;
        logic [5:0] ops[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};

        // Reset with random inputs: every output must sit at zero.
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            op = 6'($urandom); tx_full = 1'($urandom);
            tick();
            chk("rst_outputs", {busy, done, err_timeout, wr_uart, rd_uart, w_data, result}, 0);
        end
        start = 1'b0; tx_full = 1'b0;
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_no_strobes", wr_cnt + rd_cnt + done_cnt + to_cnt, 0);
        chk("idle_not_busy", {31'b0, busy}, 0);

        // Nominal frame, then backpressure after the A write.
        frame(8'h12, 8'h34, 6'h20, 0, 0, 10);
        frame(8'h12, 8'h34, 6'h20, 5, 0, 3);
        frame(8'h55, 8'h0F, 6'h24, 0, 1, 0);

        // Timeout followed by a late byte that must only be drained.
        frame(8'hA5, 8'h5A, 6'h26, 0, 2, 0);
        repeat (20) tick();
        r_before = rd_cnt; d_before = done_cnt;
        inj_q.push_back(8'h77);
        repeat (6) tick();
        chk("late_byte_drained", rd_cnt - r_before, 1);
        chk("late_byte_no_done", done_cnt - d_before, 0);
        chk("late_byte_result_kept", {24'b0, result}, {24'b0, prev_res});

        // Two stale bytes ahead of a request.
        r_before = rd_cnt;
        inj_q.push_back(8'hDE);
        inj_q.push_back(8'hAD);
        repeat (2) tick();
        frame(8'h03, 8'h04, 6'h22, 0, 0, 2);
        chk("stale_plus_result_pops", rd_cnt - r_before, 3);

        // Randomised frames.
        for (int i = 0; i < 10; i++) begin
            frame(8'($urandom), 8'($urandom), ops[$urandom_range(0, 5)],
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 6));
            repeat ($urandom_range(0, 3)) tick();
        end

        // Reset asserted while in SEND_B.
        w0 = wr_cnt;
        exp_tx.push_back(8'hC3); exp_tx.push_back(8'h3C); exp_tx.push_back(8'h25);
        start = 1'b1; a = 8'hC3; b = 8'h3C; op = 6'h25;
        tick();
        start = 1'b0;
        wait_wr(w0 + 1, ok);
        rst_n = 1'b0;
        #1;
        chk("midframe_rst_outputs", {busy, done, err_timeout, wr_uart, rd_uart, w_data, result}, 0);
        exp_tx.delete();
        prev_res = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        frame(8'hFF, 8'h01, 6'h20, 0, 0, 4);

        repeat (3) tick();
        chk("tx_expect_drained", exp_tx.size(), 0);
        chk("res_expect_drained", exp_res.size(), 0);
        chk("timeout_expect_drained", exp_to, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
